// File: rtl/aes_io_pkg.sv
// aes_io_pkg: FSM states, host word map and word-slice helper shared by the AES share I/O block.
package aes_io_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_CRST, ST_START, ST_WAIT, ST_CAPT} state_e;
    localparam int PT1_BASE  = 0;
    localparam int PT2_BASE  = 4;
    localparam int KEY1_BASE = 8;
    localparam int KEY2_BASE = 12;
    localparam int CT2_BASE  = 4;
    // Word index 0 is the most significant 32 bits of a 128-bit share.
    function automatic logic [6:0] word_lsb(input logic [1:0] idx);
        return {~idx, 5'b0};
    endfunction
endpackage

// File: rtl/share_word_bank.sv
// share_word_bank: four 128-bit share registers written one 32-bit word at a time.
module share_word_bank
    import aes_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [3:0]        addr_i,
    input  logic [31:0]       wdata_i,
    output logic [3:0][127:0] bank_o
);
    logic [3:0][127:0] bank_q, bank_d;
    always_comb begin
        bank_d = bank_q;
        if (we_i) bank_d[addr_i[3:2]][word_lsb(addr_i[1:0]) +: 32] = wdata_i;
    end
    always_ff @(posedge clk) bank_q <= rst ? '0 : bank_d;
    assign bank_o = bank_q;
endmodule

// File: rtl/aes_share_io_ctrl.sv
// aes_share_io_ctrl: host-side share loader, run sequencer with watchdog, and ciphertext share capture for aes_top.
module aes_share_io_ctrl
    import aes_io_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic         clk,
    input  logic         global_reset,
    input  logic         wr_en,
    input  logic [3:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         cmd_start,
    input  logic [2:0]   rd_addr,
    output logic [31:0]  rd_data,
    output logic         busy,
    output logic         result_valid,
    output logic         timeout_err,
    output logic         core_reset,
    output logic         core_start,
    output logic [127:0] pt_share1,
    output logic [127:0] pt_share2,
    output logic [127:0] key_share1,
    output logic [127:0] key_share2,
    input  logic [127:0] core_ct_share1,
    input  logic [127:0] core_ct_share2,
    input  logic         core_done
);
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q, rv_q, terr_q, crst_q, cstart_q;
    logic [127:0]      ct1_q, ct2_q, rd_ct;
    logic [3:0][127:0] bank;

    // Inputs are frozen outside IDLE so the core sees stable shares for the whole run.
    share_word_bank u_bank (
        .clk     (clk),
        .rst     (global_reset),
        .we_i    (wr_en && state_q == ST_IDLE),
        .addr_i  (wr_addr),
        .wdata_i (wr_data),
        .bank_o  (bank)
    );

    assign pt_share1  = bank[PT1_BASE/4];
    assign pt_share2  = bank[PT2_BASE/4];
    assign key_share1 = bank[KEY1_BASE/4];
    assign key_share2 = bank[KEY2_BASE/4];

    always_ff @(posedge clk) begin
        if (global_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            terr_q   <= 1'b0;
            crst_q   <= 1'b0;
            cstart_q <= 1'b0;
            ct1_q    <= '0;
            ct2_q    <= '0;
        end else begin
            crst_q   <= 1'b0;
            cstart_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (cmd_start) begin
                    state_q <= ST_CRST;
                    busy_q  <= 1'b1;
                    rv_q    <= 1'b0;
                    terr_q  <= 1'b0;
                    crst_q  <= 1'b1;
                end
                ST_CRST: begin
                    state_q  <= ST_START;
                    cstart_q <= 1'b1;
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= '0;
                end
                ST_WAIT: if (core_done) state_q <= ST_CAPT;
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    terr_q  <= 1'b1;
                    crst_q  <= 1'b1;
                end else cnt_q <= cnt_q + CNT_W'(1);
                ST_CAPT: begin
                    state_q <= ST_IDLE;
                    ct1_q   <= core_ct_share1;
                    ct2_q   <= core_ct_share2;
                    rv_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_ct        = (rd_addr >= 3'(CT2_BASE)) ? ct2_q : ct1_q;
    assign rd_data      = rd_ct[word_lsb(rd_addr[1:0]) +: 32];
    assign busy         = busy_q;
    assign result_valid = rv_q;
    assign timeout_err  = terr_q;
    assign core_reset   = crst_q | global_reset;
    assign core_start   = cstart_q;
endmodule

// File: tb/tb_aes_share_io_ctrl.sv
// tb_aes_share_io_ctrl: directed bench with a behavioural masked-core stand-in.
module tb_aes_share_io_ctrl;
    localparam logic [127:0] PT1A = 128'hCAFEBABECAFEBABECAFEBABECAFEBABE;
    localparam logic [127:0] PT2A = 128'hA13F045CE4BE252823C3C4AFB96DAD94;
    localparam logic [127:0] K1A  = 128'hFEEDFACEFEEDFACEFEEDFACEFEEDFACE;
    localparam logic [127:0] K2A  = 128'hD593EFD8D6432868551AEF46F722B5F2;
    localparam logic [127:0] CTA  = 128'h3AD77BB40D7A3660A89ECAF32466EF97;
    localparam logic [127:0] PT1B = 128'h1234567890ABCDEFFEDCBA0987654321;
    localparam logic [127:0] PT2B = 128'hBC19DC2F8EA86173606BD5A5C2CACD70;
    localparam logic [127:0] K1B  = 128'h0BADF00D0BADF00D0BADF00D0BADF00D;
    localparam logic [127:0] K2B  = 128'h20D3E51B230322ABA05AE5850262BF31;
    localparam logic [127:0] CTB  = 128'hF5D3D58503B9699DE785895A96FDBAAF;
    localparam logic [127:0] MASK = 128'h11111111222222223333333344444444;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         global_reset = 1'b1, wr_en = 1'b0, cmd_start = 1'b0;
    logic [3:0]   wr_addr = '0;
    logic [31:0]  wr_data = '0;
    logic [2:0]   rd_addr = '0;
    logic [31:0]  rd_data;
    logic         busy, result_valid, timeout_err, core_reset, core_start;
    logic [127:0] pt_share1, pt_share2, key_share1, key_share2;
    logic [127:0] ct1 = '0, ct2 = '0;
    logic         core_done = 1'b0;

    aes_share_io_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .global_reset(global_reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cmd_start(cmd_start), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .result_valid(result_valid), .timeout_err(timeout_err),
        .core_reset(core_reset), .core_start(core_start), .pt_share1(pt_share1),
        .pt_share2(pt_share2), .key_share1(key_share1), .key_share2(key_share2),
        .core_ct_share1(ct1), .core_ct_share2(ct2), .core_done(core_done)
    );

    // Core stand-in: known AES vectors by recombined input, done 5 cycles after start, held until reset.
    logic never_done = 1'b0;
    int   dly = 0;
    function automatic logic [127:0] ref_ct(input logic [127:0] p, input logic [127:0] k);
        if (p == (PT1A ^ PT2A) && k == (K1A ^ K2A)) return CTA;
        if (p == (PT1B ^ PT2B) && k == (K1B ^ K2B)) return CTB;
        return p ^ {k[63:0], k[127:64]};
    endfunction
    always @(posedge clk) begin
        if (core_reset) begin
            core_done <= 1'b0;
            dly <= 0;
        end else if (core_start) dly <= 5;
        else if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1 && !never_done) begin
                core_done <= 1'b1;
                ct1 <= MASK;
                ct2 <= MASK ^ ref_ct(pt_share1 ^ pt_share2, key_share1 ^ key_share2);
            end
        end
    end

    int passed = 0, total = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input logic [127:0] v, input int i);
        return v[127-32*i -: 32];
    endfunction
    function automatic logic [127:0] share_sel(input logic [3:0] a);
        return a[3:2] == 2'd0 ? pt_share1 : a[3:2] == 2'd1 ? pt_share2 : a[3:2] == 2'd2 ? key_share1 : key_share2;
    endfunction

    task automatic write_word(input logic [3:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    task automatic load(input logic [127:0] p1, input logic [127:0] p2, input logic [127:0] k1, input logic [127:0] k2);
        for (int i = 0; i < 4; i++) begin
            write_word(4'(i), wd(p1, i));
            write_word(4'(4 + i), wd(p2, i));
            write_word(4'(8 + i), wd(k1, i));
            write_word(4'(12 + i), wd(k2, i));
        end
    endtask
    task automatic read_ct(output logic [127:0] c1, output logic [127:0] c2);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            if (i < 4) c1[127-32*i -: 32] = rd_data;
            else c2[127-32*(i-4) -: 32] = rd_data;
        end
    endtask

    task automatic do_run(input string tag, input logic [127:0] exp_ct);
        logic [127:0] c1, c2;
        int nr, ns;
        logic got;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk1({tag, " busy_n1"}, busy, 1'b1);
        chk1({tag, " crst_n1"}, core_reset, 1'b1);
        chk1({tag, " cstart_n1"}, core_start, 1'b0);
        tick();
        chk1({tag, " cstart_n2"}, core_start, 1'b1);
        chk1({tag, " crst_n2"}, core_reset, 1'b0);
        nr = 0; ns = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            nr += int'(core_reset);
            ns += int'(core_start);
            got = core_done;
        end
        chk1({tag, " done_seen"}, got, 1'b1);
        tick();
        chk1({tag, " rv_at_D"}, result_valid, 1'b0);
        tick();
        chk1({tag, " rv_D1"}, result_valid, 1'b1);
        chk1({tag, " busy_D1"}, busy, 1'b0);
        chk({tag, " extra_pulses"}, 128'(nr + ns), 128'(0));
        read_ct(c1, c2);
        chk({tag, " ct1"}, c1, MASK);
        chk({tag, " recombined"}, c1 ^ c2, exp_ct);
    endtask

    typedef struct { logic [3:0] addr; logic [31:0] data; } wvec_t;
    typedef struct { logic [2:0] addr; logic [31:0] exp; } rvec_t;
    wvec_t wtab[16];
    rvec_t rtab[8];

    initial begin
        logic [127:0] c1, c2, saved;
        int ns;
        for (int i = 0; i < 16; i++) begin
            wtab[i].addr = 4'(i);
            wtab[i].data = wd(i < 4 ? PT1A : i < 8 ? PT2A : i < 12 ? K1A : K2A, i % 4);
        end
        rtab = '{'{3'd0, 32'h11111111}, '{3'd1, 32'h22222222}, '{3'd2, 32'h33333333}, '{3'd3, 32'h44444444},
                 '{3'd4, 32'h2BC66AA5}, '{3'd5, 32'h2F581442}, '{3'd6, 32'h9BADF9C0}, '{3'd7, 32'h6022ABD3}};

        repeat (2) tick();
        chk1("crst_in_reset", core_reset, 1'b1);
        global_reset = 1'b0;
        #1;
        chk1("rst_core_reset", core_reset, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rv", result_valid, 1'b0);
        chk1("rst_terr", timeout_err, 1'b0);
        chk1("rst_cstart", core_start, 1'b0);
        chk("rst_rd", 128'(rd_data), 128'(0));
        chk("rst_key2", key_share2, 128'(0));

        for (int i = 0; i < 16; i++) begin
            write_word(wtab[i].addr, wtab[i].data);
            chk($sformatf("wr_word%0d", i), 128'(wd(share_sel(wtab[i].addr), int'(wtab[i].addr[1:0]))), 128'(wtab[i].data));
        end
        chk("pt1_A", pt_share1, PT1A);
        chk("key2_A", key_share2, K2A);

        do_run("run1", CTA);
        for (int i = 0; i < 8; i++) begin
            rd_addr = rtab[i].addr;
            #1;
            chk($sformatf("rd%0d", i), 128'(rd_data), 128'(rtab[i].exp));
        end
        load(PT1B, PT2B, K1B, K2B);
        do_run("run2", CTB);
        load(PT1A, PT2A, K1A, K2A);
        do_run("run3", CTA);
        load(PT1B, PT2B, K1B, K2B);
        do_run("run4", CTB);

        // Watchdog run with blocked writes/starts mid-run.
        saved = pt_share1;
        never_done = 1'b1;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        ns = 0;
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) tick();
            if (c >= 3) ns += int'(core_start);
            if (c == 18) begin
                chk1("to_busy_c18", busy, 1'b1);
                chk1("to_terr_c18", timeout_err, 1'b0);
            end
            if (c == 5) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hDEADBEEF; cmd_start = 1'b1; end
            if (c == 6) begin wr_en = 1'b0; cmd_start = 1'b0; end
        end
        chk1("to_terr", timeout_err, 1'b1);
        chk1("to_busy", busy, 1'b0);
        chk1("to_crst", core_reset, 1'b1);
        chk1("to_rv", result_valid, 1'b0);
        chk("busy_no_restart", 128'(ns), 128'(0));
        chk("busy_wr_ignored", pt_share1, saved);
        read_ct(c1, c2);
        chk("to_ct_kept", c1 ^ c2, CTB);
        never_done = 1'b0;

        // Same-cycle write and start.
        load(PT1A, PT2A, K1A, K2A);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h00000001; cmd_start = 1'b1;
        tick();
        wr_en = 1'b0; cmd_start = 1'b0;
        tick();
        chk1("sc_cstart", core_start, 1'b1);
        chk("sc_word3", 128'(pt_share1[31:0]), 128'(32'h00000001));
        chk("sc_upper", 128'(pt_share1[127:32]), 128'(PT1A[127:32]));
        for (int i = 0; i < 40 && busy; i++) tick();
        chk1("sc_done", result_valid, 1'b1);
        chk1("sc_terr_cleared", timeout_err, 1'b0);

        // Reset in the middle of WAIT.
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (4) tick();
        chk1("gr_busy_before", busy, 1'b1);
        global_reset = 1'b1;
        #1;
        chk1("gr_crst", core_reset, 1'b1);
        tick();
        global_reset = 1'b0;
        rd_addr = 3'd0;
        #1;
        chk1("gr_busy", busy, 1'b0);
        chk1("gr_rv", result_valid, 1'b0);
        chk("gr_rd", 128'(rd_data), 128'(0));
        chk("gr_pt1", pt_share1, 128'(0));
        chk1("gr_crst_after", core_reset, 1'b0);
        tick();
        chk1("gr_idle_cstart", core_start, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1);
    end
endmodule
